// File: rtl/picotsn_eth_pkg.sv
// Shared Ethernet constants and types for the picotsn MAC datapath.
package picotsn_eth_pkg;

    localparam logic [7:0]  ETH_PREAMBLE  = 8'h55;
    localparam logic [7:0]  ETH_SFD       = 8'hD5;

    localparam logic [31:0] CRC32_POLY    = 32'hEDB8_8320;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB_20E3;

    // Preamble bytes tolerated before the SFD; one more 0x55 aborts the frame.
    localparam logic [2:0]  PRE_CNT_MAX   = 3'd7;

    // Bytes held back so the trailing FCS never reaches the payload stream.
    localparam int          DLY_DEPTH     = 5;

    typedef enum logic [1:0] {
        IDLE,
        PREAMBLE,
        DATA,
        DROP
    } rx_state_e;

endpackage

// File: rtl/crc32_d8.sv
// Combinational byte-wide step of the reflected CRC-32 (poly 0xEDB88320, LSB first).
module crc32_d8
    import picotsn_eth_pkg::*;
(
    input  logic [31:0] crc_i,
    input  logic [7:0]  data_i,
    output logic [31:0] crc_o
);

    logic [31:0] crc_step;

    always_comb begin
        crc_step = crc_i;
        for (int i = 0; i < 8; i++) begin
            if (crc_step[0] ^ data_i[i]) begin
                crc_step = (crc_step >> 1) ^ CRC32_POLY;
            end else begin
                crc_step = crc_step >> 1;
            end
        end
        crc_o = crc_step;
    end

endmodule

// File: rtl/gmii_rx_deframer.sv
// GMII receive deframer: strips preamble/SFD and FCS, checks CRC-32 and length,
// and streams payload bytes with sop/eop/err/len markers plus per-frame status pulses.
module gmii_rx_deframer
    import picotsn_eth_pkg::*;
#(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518
) (
    input  logic        gmii_rx_clk,
    input  logic        rst,
    input  logic [7:0]  gmii_rxd,
    input  logic        gmii_rx_dv,
    input  logic        gmii_rx_er,
    output logic        pkt_valid,
    output logic [7:0]  pkt_data,
    output logic        pkt_sop,
    output logic        pkt_eop,
    output logic        pkt_err,
    output logic [15:0] pkt_len,
    output logic        stat_good,
    output logic        stat_bad,
    output logic        stat_drop
);

    localparam logic [15:0] MIN_LEN_W = 16'(MIN_LEN);
    localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);
    localparam logic [2:0]  FILL_FULL = 3'(DLY_DEPTH);

    rx_state_e   state_q;
    logic [2:0]  pre_cnt_q;
    logic [2:0]  fill_q;
    logic        sop_pend_q;
    logic        rx_er_q;
    logic [7:0]  dly_q [DLY_DEPTH];
    logic [31:0] crc_q;
    logic [31:0] crc_d;
    logic [15:0] n_q;
    logic [15:0] n_d;
    logic        frame_err_d;

    crc32_d8 u_crc (
        .crc_i  (crc_q),
        .data_i (gmii_rxd),
        .crc_o  (crc_d)
    );

    // Checked on the dv falling edge, when crc_q/n_q already cover the FCS.
    always_comb begin
        n_d         = (n_q == 16'hFFFF) ? n_q : n_q + 16'd1;
        frame_err_d = (crc_q != CRC32_RESIDUE) || rx_er_q
                   || (n_q < MIN_LEN_W) || (n_q > MAX_LEN_W);
    end

    always_ff @(posedge gmii_rx_clk) begin
        pkt_valid <= 1'b0;
        pkt_sop   <= 1'b0;
        pkt_eop   <= 1'b0;
        pkt_err   <= 1'b0;
        stat_good <= 1'b0;
        stat_bad  <= 1'b0;
        stat_drop <= 1'b0;

        if (rst) begin
            state_q    <= IDLE;
            pre_cnt_q  <= '0;
            fill_q     <= '0;
            sop_pend_q <= 1'b0;
            rx_er_q    <= 1'b0;
            crc_q      <= CRC32_INIT;
            n_q        <= '0;
            pkt_data   <= '0;
            pkt_len    <= '0;
            for (int i = 0; i < DLY_DEPTH; i++) begin
                dly_q[i] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (gmii_rx_dv) begin
                        if (gmii_rxd == ETH_PREAMBLE) begin
                            state_q   <= PREAMBLE;
                            pre_cnt_q <= 3'd1;
                        end else begin
                            state_q <= DROP;
                        end
                    end
                end

                PREAMBLE: begin
                    if (!gmii_rx_dv) begin
                        state_q <= IDLE;
                    end else if (gmii_rxd == ETH_SFD) begin
                        state_q    <= DATA;
                        crc_q      <= CRC32_INIT;
                        n_q        <= '0;
                        fill_q     <= '0;
                        sop_pend_q <= 1'b1;
                        rx_er_q    <= 1'b0;
                    end else if (gmii_rxd == ETH_PREAMBLE && pre_cnt_q != PRE_CNT_MAX) begin
                        pre_cnt_q <= pre_cnt_q + 3'd1;
                    end else begin
                        state_q <= DROP;
                    end
                end

                DATA: begin
                    if (gmii_rx_dv) begin
                        crc_q    <= crc_d;
                        n_q      <= n_d;
                        rx_er_q  <= rx_er_q | gmii_rx_er;
                        dly_q[0] <= gmii_rxd;
                        for (int i = 1; i < DLY_DEPTH; i++) begin
                            dly_q[i] <= dly_q[i-1];
                        end
                        if (fill_q == FILL_FULL) begin
                            pkt_valid  <= 1'b1;
                            pkt_data   <= dly_q[DLY_DEPTH-1];
                            pkt_sop    <= sop_pend_q;
                            sop_pend_q <= 1'b0;
                        end else begin
                            fill_q <= fill_q + 3'd1;
                        end
                    end else begin
                        state_q <= IDLE;
                        // A full line means at least one payload byte precedes the FCS.
                        if (fill_q == FILL_FULL) begin
                            pkt_valid <= 1'b1;
                            pkt_data  <= dly_q[DLY_DEPTH-1];
                            pkt_sop   <= sop_pend_q;
                            pkt_eop   <= 1'b1;
                            pkt_err   <= frame_err_d;
                            pkt_len   <= n_q - 16'd4;
                            stat_good <= !frame_err_d;
                            stat_bad  <= frame_err_d;
                        end else begin
                            stat_drop <= 1'b1;
                        end
                        sop_pend_q <= 1'b0;
                        fill_q     <= '0;
                    end
                end

                DROP: begin
                    if (!gmii_rx_dv) begin
                        stat_drop <= 1'b1;
                        state_q   <= IDLE;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
